// File: rtl/inv_park_mc.sv
// inv_park_mc: multi-channel inverse Park transform built on an iterative CORDIC sin/cos.
// Define INV_PARK_SAT_EN to clamp alpha/beta to DW bits; otherwise they wrap.
module cordic (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iCordic_en,
    input  logic [19:0]        iTheta,
    output logic signed [15:0] oSin,
    output logic signed [15:0] oCos,
    output logic               oCordic_done
);
    localparam int N = 18;
    // atan(2^-i) scaled so that one revolution is 2^24
    localparam logic [21:0] ATAN [N] = '{22'd2097152, 22'd1238021, 22'd654136, 22'd332050,
        22'd166669, 22'd83416, 22'd41718, 22'd20860, 22'd10430, 22'd5215, 22'd2608,
        22'd1304, 22'd652, 22'd326, 22'd163, 22'd81, 22'd41, 22'd20};
    logic signed [26:0] x, y;
    logic signed [24:0] z, atan;
    logic signed [15:0] c, s;
    logic [1:0] quad;
    logic [4:0] it;
    logic run, ccw;
    function automatic logic signed [15:0] q15(input logic signed [26:0] v);
        logic signed [26:0] r;
        r = (v + 27'sd256) >>> 9;
        return (r > 27'sd32767) ? 16'sh7fff : (r < -27'sd32768) ? 16'sh8000 : r[15:0];
    endfunction
    assign atan = $signed({3'b000, ATAN[it]});
    assign ccw = !z[24];
    assign c = q15(x);
    assign s = q15(y);
    // rotate the first-quadrant result into the quadrant given by the top angle bits
    assign oCos = quad == 2'd0 ? c : quad == 2'd1 ? -s : quad == 2'd2 ? -c : s;
    assign oSin = quad == 2'd0 ? s : quad == 2'd1 ? c : quad == 2'd2 ? -s : -c;
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            x <= '0;
            y <= '0;
            z <= '0;
            quad <= '0;
            it <= '0;
            run <= 1'b0;
            oCordic_done <= 1'b0;
        end else if (iCordic_en) begin
            x <= 27'sd10188014;
            y <= '0;
            z <= $signed({3'b000, iTheta[17:0], 4'b0000});
            quad <= iTheta[19:18];
            it <= '0;
            run <= 1'b1;
            oCordic_done <= 1'b0;
        end else if (run) begin
            x <= ccw ? x - (y >>> it) : x + (y >>> it);
            y <= ccw ? y + (x >>> it) : y - (x >>> it);
            z <= ccw ? z - atan : z + atan;
            if (it == 5'(N - 1)) begin
                run <= 1'b0;
                oCordic_done <= 1'b1;
            end else begin
                it <= it + 5'd1;
            end
        end
    end
endmodule

module inv_park_mc #(
    parameter int DW  = 16,
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iIP_en,
    input  logic [CHW-1:0]        iCh,
    input  logic signed [DW-1:0]  iVd,
    input  logic signed [DW-1:0]  iVq,
    input  logic [19:0]           iTheta,
    output logic                  oBusy,
    output logic                  oIP_done,
    output logic                  oErr,
    output logic [CHW-1:0]        oCh,
    output logic [NCH*DW-1:0]     oValpha_bus,
    output logic [NCH*DW-1:0]     oVbeta_bus
);
    typedef enum logic [1:0] {IDLE, WAIT_CS, SUM} state_t;
    state_t state, nxt;
    logic en_q, arm, done_q, rise, accept, cs_rise, cordic_en, cordic_done;
    logic signed [15:0] sin_v, cos_v;
    logic signed [DW-1:0] vd_l, vq_l, alpha, beta;
    logic [CHW-1:0] ch_l;
    logic signed [DW+15:0] dc, ds, qc, qs;
    logic signed [DW:0] a_w, b_w;
    function automatic logic signed [DW+15:0] mul(input logic signed [DW-1:0] v, input logic signed [15:0] t);
        logic signed [DW+15:0] p;
        p = v * t;
        return p >>> 15;
    endfunction
    function automatic logic signed [DW-1:0] red(input logic signed [DW:0] v);
`ifdef INV_PARK_SAT_EN
        return (v[DW] != v[DW-1]) ? {v[DW], {(DW-1){~v[DW]}}} : v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction
    cordic u_cordic (
        .iClk(iClk),
        .iRst_n(iRst_n),
        .iCordic_en(cordic_en),
        .iTheta(iTheta),
        .oSin(sin_v),
        .oCos(cos_v),
        .oCordic_done(cordic_done)
    );
    // arm stays low after reset until iIP_en is seen low, so a held request cannot start
    assign rise = iIP_en && !en_q && arm;
    assign accept = rise && state == IDLE && !oIP_done && (32'(iCh) < NCH);
    assign cs_rise = cordic_done && !done_q;
    assign a_w = dc[DW:0] - qs[DW:0];
    assign b_w = ds[DW:0] + qc[DW:0];
    assign alpha = red(a_w);
    assign beta = red(b_w);
    always_comb begin
        nxt = IDLE;
        cordic_en = 1'b0;
        case (state)
            IDLE: begin
                nxt = accept ? WAIT_CS : IDLE;
                cordic_en = accept;
            end
            WAIT_CS: nxt = cs_rise ? SUM : WAIT_CS;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
            en_q <= 1'b0;
            arm <= 1'b0;
            done_q <= 1'b0;
            vd_l <= '0;
            vq_l <= '0;
            ch_l <= '0;
            dc <= '0;
            ds <= '0;
            qc <= '0;
            qs <= '0;
            oBusy <= 1'b0;
            oIP_done <= 1'b0;
            oErr <= 1'b0;
            oCh <= '0;
            oValpha_bus <= '0;
            oVbeta_bus <= '0;
        end else begin
            state <= nxt;
            en_q <= iIP_en;
            arm <= arm | ~iIP_en;
            done_q <= cordic_done;
            oErr <= rise && !accept;
            oIP_done <= state == SUM;
            if (accept) begin
                vd_l <= iVd;
                vq_l <= iVq;
                ch_l <= iCh;
                oBusy <= 1'b1;
            end
            if (state == WAIT_CS && cs_rise) begin
                dc <= mul(vd_l, cos_v);
                ds <= mul(vd_l, sin_v);
                qc <= mul(vq_l, cos_v);
                qs <= mul(vq_l, sin_v);
            end
            if (state == SUM) begin
                oBusy <= 1'b0;
                oCh <= ch_l;
                oValpha_bus[ch_l*DW +: DW] <= alpha;
                oVbeta_bus[ch_l*DW +: DW] <= beta;
            end
        end
    end
endmodule

// File: tb/tb_inv_park_mc.sv
// tb_inv_park_mc: scoreboard bench for inv_park_mc with a real-valued sin/cos reference.
// Follows INV_PARK_SAT_EN the same way the design does.
module tb_inv_park_mc;
    localparam int DW = 16, NCH = 3, CHW = 2;
    localparam real PI = 3.14159265358979;
    logic iClk = 1'b0, iRst_n = 1'b0, iIP_en = 1'b0;
    logic [CHW-1:0] iCh = '0;
    logic signed [DW-1:0] iVd = '0, iVq = '0;
    logic [19:0] iTheta = '0;
    logic oBusy, oIP_done, oErr;
    logic [CHW-1:0] oCh;
    logic [NCH*DW-1:0] oValpha_bus, oVbeta_bus;

    inv_park_mc #(.DW(DW), .NCH(NCH), .CHW(CHW)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iIP_en(iIP_en), .iCh(iCh), .iVd(iVd), .iVq(iVq),
        .iTheta(iTheta), .oBusy(oBusy), .oIP_done(oIP_done), .oErr(oErr), .oCh(oCh),
        .oValpha_bus(oValpha_bus), .oVbeta_bus(oVbeta_bus)
    );

    always #5 iClk = ~iClk;

    typedef struct { int ch; int a; int b; int tol; } exp_t;
    exp_t sb[$];
    exp_t e;
    int mdl_a[NCH], mdl_b[NCH], mdl_tol[NCH];
    int n_vec = 0, n_bad = 0, n_done = 0, exp_done = 0, n_err = 0, exp_err = 0;
    int cyc = 0, rise_cyc = 0;
    logic cd_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_vec++;
        if (got > exp + tol || got < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int q15(input real v);
        int r;
        r = int'(v * 32768.0);
        return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
    endfunction

    function automatic int red(input int v);
        int lim;
        lim = 1 << (DW - 1);
`ifdef INV_PARK_SAT_EN
        return v > lim - 1 ? lim - 1 : v < -lim ? -lim : v;
`else
        return ((v + lim) & (2 * lim - 1)) - lim;
`endif
    endfunction

    task automatic req(input int ch, input int vd, input int vq, input int th, input bit ok, input int tol);
        real ang;
        int c, s;
        ang = real'(th) * 2.0 * PI / 1048576.0;
        c = q15($cos(ang));
        s = q15($sin(ang));
        @(negedge iClk);
        iCh = CHW'(ch);
        iVd = DW'(vd);
        iVq = DW'(vq);
        iTheta = 20'(th);
        iIP_en = 1'b1;
        if (ok) begin
            sb.push_back('{ch, red(((vd * c) >>> 15) - ((vq * s) >>> 15)),
                               red(((vd * s) >>> 15) + ((vq * c) >>> 15)), tol});
            exp_done++;
        end else begin
            exp_err++;
        end
        @(negedge iClk);
        iIP_en = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while ((sb.size() != 0 || oBusy) && i < 200) begin
            @(negedge iClk);
            i++;
        end
        check("idle", sb.size() + int'(oBusy), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(oBusy), 0);
        check({tag, "_done"}, int'(oIP_done), 0);
        check({tag, "_err"}, int'(oErr), 0);
        check({tag, "_ch"}, int'(oCh), 0);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s_a%0d", tag, k), int'($signed(oValpha_bus[k*DW +: DW])), 0);
            check($sformatf("%s_b%0d", tag, k), int'($signed(oVbeta_bus[k*DW +: DW])), 0);
        end
    endtask

    initial forever begin
        @(posedge iClk);
        #1;
        cyc++;
        if (!cd_prev && dut.cordic_done) rise_cyc = cyc;
        cd_prev = dut.cordic_done;
        if (oErr) n_err++;
        if (oIP_done) begin
            n_done++;
            check("latency", cyc - rise_cyc, 2);
            check("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                mdl_a[e.ch] = e.a;
                mdl_b[e.ch] = e.b;
                mdl_tol[e.ch] = e.tol;
                check("och", int'(oCh), e.ch);
                for (int k = 0; k < NCH; k++) begin
                    check($sformatf("alpha%0d", k), int'($signed(oValpha_bus[k*DW +: DW])), mdl_a[k], mdl_tol[k]);
                    check($sformatf("beta%0d", k), int'($signed(oVbeta_bus[k*DW +: DW])), mdl_b[k], mdl_tol[k]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, n_done %0d want %0d", n_done, exp_done);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        for (int k = 0; k < NCH; k++) begin
            mdl_a[k] = 0;
            mdl_b[k] = 0;
            mdl_tol[k] = 0;
        end
        repeat (3) @(negedge iClk);
        check_zero("rst");
        iRst_n = 1'b1;
        repeat (2) @(negedge iClk);
        req(0, 16384, 0, 0, 1'b1, 0);
        wait_done();
        req(1, 0, 8192, 'h40000, 1'b1, 2);
        wait_done();
        req(0, 32767, -32768, 'h20000, 1'b1, 2);
        wait_done();
        for (int i = 0; i < 6; i++) begin
            req(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 32000)) - 16000,
                int'($urandom_range(0, 32000)) - 16000, int'($urandom_range(0, 20'hfffff)), 1'b1, 2);
            wait_done();
        end
        req(NCH, 1234, 4321, 'h11111, 1'b0, 0);
        repeat (3) @(negedge iClk);
        check("bad_ch_busy", int'(oBusy), 0);
        req(2, 1000, 2000, 'h12345, 1'b1, 2);
        repeat (2) @(negedge iClk);
        req(1, 5000, 5000, 0, 1'b0, 0);
        wait_done();
        req(1, 3000, -4000, 'h9abcd, 1'b1, 2);
        for (int i = 0; i < 200 && !oIP_done; i++) begin
            @(posedge iClk);
            #2;
        end
        check("done_seen", int'(oIP_done), 1);
        iIP_en = 1'b1;
        exp_err++;
        @(posedge iClk);
        @(negedge iClk);
        iIP_en = 1'b0;
        repeat (2) @(negedge iClk);
        check("done_cycle_busy", int'(oBusy), 0);
        req(2, 7000, 7000, 'h30000, 1'b1, 2);
        repeat (3) @(negedge iClk);
        snap = n_done;
        iIP_en = 1'b1;
        iRst_n = 1'b0;
        exp_done -= sb.size();
        sb.delete();
        for (int k = 0; k < NCH; k++) begin
            mdl_a[k] = 0;
            mdl_b[k] = 0;
            mdl_tol[k] = 0;
        end
        @(negedge iClk);
        check_zero("midrst");
        iRst_n = 1'b1;
        repeat (30) @(negedge iClk);
        check("held_busy", int'(oBusy), 0);
        check("held_ndone", n_done, snap);
        iIP_en = 1'b0;
        @(negedge iClk);
        req(2, 7000, 7000, 'h30000, 1'b1, 2);
        wait_done();
        repeat (3) @(negedge iClk);
        check("n_err", n_err, exp_err);
        check("n_done", n_done, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/inv_park_mc.md
INV_PARK_MC -- requirements
Module: inv_park_mc

Interface
REQ-001 Parameter DW, default 16: signed width of iVd, iVq and each output voltage word.
REQ-002 Parameter NCH, default 2: number of channels (motors) served; the legal range is 1..16.
REQ-003 Parameter CHW, default 1: channel index width; CHW SHALL equal max(1, clog2(NCH)).
REQ-004 iClk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 iRst_n  in  1  reset, asynchronous assert and active-low.
REQ-006 iIP_en  in  1  request; only a rising edge starts a transform.
REQ-007 iCh  in  CHW  channel index of the request.
REQ-008 iVd, iVq  in  DW  signed d/q voltages.
REQ-009 iTheta  in  20  unsigned electrical angle; 2^20 = one revolution.
REQ-010 oBusy  out  1  high from request acceptance until the cycle oIP_done is asserted.
REQ-011 oIP_done  out  1  one-cycle pulse: result written.
REQ-012 oErr  out  1  one-cycle pulse: request rejected.
REQ-013 oCh  out  CHW  channel of the last written result.
REQ-014 oValpha_bus, oVbeta_bus  out  NCH*DW  per-channel signed results; channel k occupies bits [k*DW +: DW].

Function
REQ-015 The block SHALL instantiate the team Cordic (iCordic_en, iTheta, Q1.15 oSin/oCos, oCordic_done) and SHALL rising-edge-detect oCordic_done with a registered copy.
REQ-016 FSM states: IDLE, WAIT_CS, SUM; all other encodings SHALL go to IDLE.
REQ-017 IDLE: on an iIP_en rise with iCh < NCH, latch iVd, iVq and iCh; pulse iCordic_en combinationally that cycle; go to WAIT_CS.
REQ-018 IDLE: on an iIP_en rise with iCh >= NCH, pulse oErr next cycle; no state change and no Cordic start.
REQ-019 An iIP_en rise while in WAIT_CS or SUM SHALL be ignored and SHALL pulse oErr next cycle; the in-flight transform SHALL complete unaffected.
REQ-020 WAIT_CS: on the oCordic_done rising edge, register dc = (Vd*cos)>>>15, ds = (Vd*sin)>>>15, qc = (Vq*cos)>>>15 and qs = (Vq*sin)>>>15 as full-precision signed (DW+16) products; go to SUM.
REQ-021 SUM: compute alpha = dc-qs and beta = ds+qc at DW+1 bits and reduce them to DW bits per REQ-028.
REQ-022 SUM: write alpha and beta to the latched channel's slice only, set oCh, pulse oIP_done, and go to IDLE.
REQ-023 Other channels' slices SHALL hold their values.
REQ-024 Latency: oIP_done SHALL be high exactly 2 cycles after the cycle in which the oCordic_done rise is first visible.
REQ-025 An iIP_en rise in the same cycle oIP_done is high (SUM state) SHALL be rejected per REQ-019.

Reset
REQ-026 While iRst_n is low: state = IDLE; all product registers and output slices = 0; oCh = 0; oBusy = 0; oIP_done = 0; oErr = 0; edge-detect registers = 0.
REQ-027 Reset asserted mid-transform SHALL abort it with no oIP_done; after release, an iIP_en already held high SHALL NOT start a transform until it falls and rises again.

Configuration
REQ-028 Macro INV_PARK_SAT_EN: when defined, alpha and beta SHALL clamp to [-2^(DW-1), 2^(DW-1)-1]; when undefined, the low DW bits SHALL be taken (two's-complement wrap).

Verification
REQ-029 Reset, ch0, Vd=16384, Vq=0, theta=0 -> slice0 alpha=16383, beta=0; slice1 stays 0; one oIP_done; oCh=0.
REQ-030 ch1, Vd=0, Vq=8192, theta=0x40000 -> slice1 alpha=-8192±2, beta=0±2; slice0 unchanged.
REQ-031 Vd=32767, Vq=-32768, theta=0x20000 -> with INV_PARK_SAT_EN alpha=32767; without it alpha=-19197±2; beta=-1±2 in both builds.
REQ-032 Second iIP_en rise during WAIT_CS -> oErr one cycle; exactly one oIP_done carrying the first request's result; iCh=NCH -> oErr, oBusy stays 0.
REQ-033 iRst_n low during WAIT_CS -> all outputs 0, no oIP_done; iIP_en held high through release -> no start until it toggles.
REQ-034 Latency check: count cycles from the oCordic_done rise to oIP_done -> must equal 2 on every transaction.
